// File: rtl/rhea_reversible_uncompute_pkg.sv
// Shared constants, state encoding and modular-subtraction helpers for the
// RHEA-UCM inverse engine.
package rhea_pkg;

  localparam int MAX_ROUNDS = 8;
  localparam int ROUND_W    = $clog2(MAX_ROUNDS + 1);
  localparam logic [ROUND_W-1:0] MAX_ROUNDS_W = MAX_ROUNDS[ROUND_W-1:0];

  localparam logic [1:0] MODE_BIN  = 2'b00;
  localparam logic [1:0] MODE_TER  = 2'b01;
  localparam logic [1:0] MODE_PENT = 2'b10;
  localparam logic [1:0] MODE_PASS = 2'b11;

  localparam logic [2:0] TER_MAX  = 3'd2;
  localparam logic [2:0] PENT_MAX = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // x - y computed as x + (r - y) with one conditional subtract of r
  function automatic logic [2:0] sub_mod3(input logic [2:0] x, input logic [2:0] y);
    logic [3:0] t;
    t = {1'b0, x} + (4'd3 - {1'b0, y});
    if (t >= 4'd3) t = t - 4'd3;
    return t[2:0];
  endfunction

  function automatic logic [2:0] sub_mod5(input logic [2:0] x, input logic [2:0] y);
    logic [3:0] t;
    t = {1'b0, x} + (4'd5 - {1'b0, y});
    if (t >= 4'd5) t = t - 4'd5;
    return t[2:0];
  endfunction

endpackage

// File: rtl/rhea_reversible_uncompute_if.sv
// Request/response bundle of the inverse engine: valid/ready request with the
// gate-output triple, and valid/ready result with the recovered triple.
interface rhea_reversible_uncompute_if ();
  import rhea_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [1:0]         mode;
  logic [ROUND_W-1:0] rounds;
  logic [2:0]         A_in;
  logic [2:0]         B_in;
  logic [2:0]         G_in;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         A_out;
  logic [2:0]         B_out;
  logic [2:0]         G_out;
  logic               err;
  logic               busy;

  modport master (
    output in_valid, mode, rounds, A_in, B_in, G_in, out_ready,
    input  in_ready, out_valid, A_out, B_out, G_out, err, busy
  );

  modport slave (
    input  in_valid, mode, rounds, A_in, B_in, G_in, out_ready,
    output in_ready, out_valid, A_out, B_out, G_out, err, busy
  );

endinterface

// File: rtl/rhea_reversible_uncompute_round.sv
// One combinational inverse round of the reversible gate; B is recovered first
// and the new B is used to recover G.
module rhea_inverse_round (
  input  logic [1:0] i_mode,
  input  logic [2:0] i_a,
  input  logic [2:0] i_b,
  input  logic [2:0] i_g,
  output logic [2:0] o_a,
  output logic [2:0] o_b,
  output logic [2:0] o_g
);
  import rhea_pkg::*;

  logic [2:0] w_b;

  always_comb begin
    o_a = i_a;
    w_b = i_b;
    o_g = i_g;
    case (i_mode)
      MODE_TER: begin
        o_a = {1'b0, i_a[1:0]};
        w_b = sub_mod3({1'b0, i_b[1:0]}, {1'b0, i_a[1:0]});
        o_g = sub_mod5(i_g, w_b);
      end
      MODE_PENT: begin
        w_b = sub_mod5(i_b, i_a);
        o_g = sub_mod5(i_g, w_b);
      end
      default: ;
    endcase
    o_b = w_b;
  end

endmodule

// File: rtl/rhea_reversible_uncompute.sv
// Sequential uncompute engine: latches a gate-output triple, applies N inverse
// rounds one per cycle through rhea_inverse_round, and returns the original.
module rhea_reversible_uncompute (
  input logic                         clk,
  input logic                         rst_n,
  rhea_reversible_uncompute_if.slave  bus
);
  import rhea_pkg::*;

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_mode;
  logic [ROUND_W-1:0] r_cnt;
  logic [2:0]         r_a;
  logic [2:0]         r_b;
  logic [2:0]         r_g;
  logic               r_err;

  logic               w_accept;
  logic               w_err;
  logic               w_direct;
  logic [2:0]         w_ra;
  logic [2:0]         w_rb;
  logic [2:0]         w_rg;

  assign w_accept = bus.in_valid && (r_state == ST_IDLE);

  always_comb begin
    w_err = 1'b0;
    case (bus.mode)
      MODE_BIN:  w_err = 1'b1;
      MODE_TER:  w_err = (bus.A_in > TER_MAX) || (bus.B_in > TER_MAX) || (bus.G_in > PENT_MAX);
      MODE_PENT: w_err = (bus.A_in > PENT_MAX) || (bus.B_in > PENT_MAX) || (bus.G_in > PENT_MAX);
      default:   w_err = 1'b0;
    endcase
    if (bus.rounds > MAX_ROUNDS_W) w_err = 1'b1;
  end

  // Errors, pass-through and zero rounds skip RUN and return the inputs as-is
  assign w_direct = w_err || (bus.mode == MODE_PASS) || (bus.rounds == '0);

  rhea_inverse_round u_round (
    .i_mode (r_mode),
    .i_a    (r_a),
    .i_b    (r_b),
    .i_g    (r_g),
    .o_a    (w_ra),
    .o_b    (w_rb),
    .o_g    (w_rg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = w_direct ? ST_DONE : ST_RUN;
      ST_RUN:  if (r_cnt == ROUND_W'(1)) w_next = ST_DONE;
      ST_DONE: if (bus.out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == ST_IDLE);
    bus.out_valid = (r_state == ST_DONE);
    bus.busy      = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_BIN;
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_g    <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mode <= bus.mode;
            r_a    <= bus.A_in;
            r_b    <= bus.B_in;
            r_g    <= bus.G_in;
            r_err  <= w_err;
            r_cnt  <= w_direct ? '0 : bus.rounds;
          end
        end
        ST_RUN: begin
          r_a   <= w_ra;
          r_b   <= w_rb;
          r_g   <= w_rg;
          r_cnt <= r_cnt - ROUND_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.A_out = r_a;
  assign bus.B_out = r_b;
  assign bus.G_out = r_g;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_rhea_reversible_uncompute.sv
// Self-checking bench for rhea_reversible_uncompute: directed vector table,
// randomized transactions against an arithmetic model, backpressure and reset.
module tb_rhea_reversible_uncompute;
  import rhea_pkg::*;

  typedef struct {
    int mode;
    int rounds;
    int a;
    int b;
    int g;
    int expA;
    int expB;
    int expG;
    int expErr;
    int expLat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   nTests;
  int   nFail;
  vec_t vecs [11];

  rhea_reversible_uncompute_if bus ();

  rhea_reversible_uncompute dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain modular arithmetic on integers, one inverse step per round
  function automatic void refModel(input int m, input int r, input int a, input int b, input int g,
                                   output int ea, output int eb, output int eg,
                                   output int ee, output int elat);
    int radix;
    ee = (r > MAX_ROUNDS) || (m == 0) ||
         (m == 1 && (a > 2 || b > 2 || g > 4)) ||
         (m == 2 && (a > 4 || b > 4 || g > 4)) ? 1 : 0;
    ea = a; eb = b; eg = g;
    if (ee == 1 || m == 3 || r == 0) begin
      elat = 1;
    end else begin
      radix = (m == 1) ? 3 : 5;
      for (int i = 0; i < r; i++) begin
        eb = (((eb - ea) % radix) + radix) % radix;
        eg = (((eg - eb) % 5) + 5) % 5;
      end
      elat = r + 1;
    end
  endfunction

  // Presents one request for a single cycle; lat counts edges from the accept
  // edge (inclusive) until out_valid is seen, capped to stay bounded.
  task automatic applyStimulus(input int m, input int r, input int a, input int b, input int g,
                               output int lat);
    bus.mode     = m[1:0];
    bus.rounds   = r[ROUND_W-1:0];
    bus.A_in     = a[2:0];
    bus.B_in     = b[2:0];
    bus.G_in     = g[2:0];
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic checkTriple(input string name, input int ea, input int eb, input int eg, input int ee);
    checkOutput({name, ".A"}, int'(bus.A_out), ea);
    checkOutput({name, ".B"}, int'(bus.B_out), eb);
    checkOutput({name, ".G"}, int'(bus.G_out), eg);
    checkOutput({name, ".err"}, int'(bus.err), ee);
  endtask

  initial begin
    int lat, ea, eb, eg, ee, elat, m, r, a, b, g, hold;
    nTests = 0;
    nFail  = 0;

    vecs[0]  = '{2, 1, 3, 1, 2, 3, 3, 4, 0, 2};
    vecs[1]  = '{1, 1, 2, 0, 1, 2, 1, 0, 0, 2};
    vecs[2]  = '{2, 2, 1, 4, 3, 1, 2, 3, 0, 3};
    vecs[3]  = '{2, 3, 5, 1, 2, 5, 1, 2, 1, 1};
    vecs[4]  = '{0, 2, 1, 1, 1, 1, 1, 1, 1, 1};
    vecs[5]  = '{3, 4, 7, 6, 5, 7, 6, 5, 0, 1};
    vecs[6]  = '{1, 0, 1, 2, 3, 1, 2, 3, 0, 1};
    vecs[7]  = '{2, 9, 1, 1, 1, 1, 1, 1, 1, 1};
    vecs[8]  = '{1, 1, 1, 1, 5, 1, 1, 5, 1, 1};
    vecs[9]  = '{2, 8, 2, 0, 0, 2, 4, 2, 0, 9};
    vecs[10] = '{1, 8, 1, 0, 0, 1, 1, 1, 0, 9};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.mode      = '0;
    bus.rounds    = '0;
    bus.A_in      = '0;
    bus.B_in      = '0;
    bus.G_in      = '0;
    rst_n         = 1'b0;
    #12;
    checkTriple("reset", 0, 0, 0, 0);
    checkOutput("reset.out_valid", int'(bus.out_valid), 0);
    checkOutput("reset.busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset.in_ready", int'(bus.in_ready), 1);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].rounds, vecs[i].a, vecs[i].b, vecs[i].g, lat);
      checkTriple($sformatf("vec%0d", i), vecs[i].expA, vecs[i].expB, vecs[i].expG, vecs[i].expErr);
      checkOutput($sformatf("vec%0d.latency", i), lat, vecs[i].expLat);
      consume();
    end

    // Intermediate working value after the first of two pentary rounds
    bus.mode = MODE_PENT; bus.rounds = 2; bus.A_in = 1; bus.B_in = 4; bus.G_in = 3;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid.A", int'(bus.A_out), 1);
    checkOutput("mid.B", int'(bus.B_out), 3);
    checkOutput("mid.G", int'(bus.G_out), 0);
    checkOutput("mid.out_valid", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    checkOutput("mid.final_valid", int'(bus.out_valid), 1);
    checkTriple("mid.final", 1, 2, 3, 0);
    consume();

    // Backpressure: result must hold while out_ready is low
    applyStimulus(2, 1, 3, 1, 2, lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkTriple($sformatf("bp%0d", c), 3, 3, 4, 0);
      checkOutput($sformatf("bp%0d.out_valid", c), int'(bus.out_valid), 1);
      checkOutput($sformatf("bp%0d.in_ready", c), int'(bus.in_ready), 0);
    end
    consume();
    checkOutput("bp.release.out_valid", int'(bus.out_valid), 0);
    checkOutput("bp.release.in_ready", int'(bus.in_ready), 1);
    checkOutput("bp.release.busy", int'(bus.busy), 0);

    // Asynchronous reset in the middle of a six-round run
    bus.mode = MODE_PENT; bus.rounds = 6; bus.A_in = 2; bus.B_in = 3; bus.G_in = 1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); end
    #2;
    rst_n = 1'b0;
    #1;
    checkTriple("midreset", 0, 0, 0, 0);
    checkOutput("midreset.out_valid", int'(bus.out_valid), 0);
    checkOutput("midreset.busy", int'(bus.busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("midreset.in_ready", int'(bus.in_ready), 1);
    refModel(2, 6, 2, 3, 1, ea, eb, eg, ee, elat);
    applyStimulus(2, 6, 2, 3, 1, lat);
    checkTriple("postreset", ea, eb, eg, ee);
    checkOutput("postreset.latency", lat, elat);
    consume();

    for (int t = 0; t < 60; t++) begin
      m = $urandom_range(0, 3);
      r = ($urandom_range(0, 7) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
      a = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : $urandom_range(0, (m == 1) ? 2 : 4);
      b = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : $urandom_range(0, (m == 1) ? 2 : 4);
      g = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 4);
      refModel(m, r, a, b, g, ea, eb, eg, ee, elat);
      applyStimulus(m, r, a, b, g, lat);
      hold = $urandom_range(0, 2);
      repeat (hold) begin @(posedge clk); end
      #1;
      checkTriple($sformatf("rnd%0d", t), ea, eb, eg, ee);
      checkOutput($sformatf("rnd%0d.latency", t), lat, elat);
      consume();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/rhea_reversible_uncompute.md
# rhea_reversible_uncompute

Sequential inverse ("uncompute") engine for the RHEA-UCM reversible multi-radix gate. It accepts a gate-output triple (A′, B′, G′), then undoes N successive forward gate applications, one per cycle, and returns the original (A, B, G). It sits beside the forward gate so that symbolic state and the glyph/trust register can be rolled back without losing information. It uses a valid/ready handshake on input and output.

## Interface
- MAX_ROUNDS, 8: largest round count accepted per transaction.
- ROUND_W, $clog2(MAX_ROUNDS+1): width of the round-count field.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  engine can accept a request (high only in IDLE).
- mode  in  2  00 = binary, 01 = ternary, 10 = pentary, 11 = pass-through.
- rounds  in  ROUND_W  number of inverse rounds to apply (0..MAX_ROUNDS).
- A_in, B_in, G_in  in  3 each  gate-output digits A′, B′, G′.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- A_out, B_out, G_out  out  3 each  recovered digits.
- err  out  1  result flag, valid with out_valid: irreversible mode, out-of-range digit, or rounds > MAX_ROUNDS.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE.** in_ready = 1. On in_valid && in_ready, latch mode, rounds, A/B/G and run the error check:
  - ternary: error if A or B > 2, or G > 4;
  - pentary: error if any digit > 4;
  - binary (00): always error, because NAND is irreversible;
  - rounds > MAX_ROUNDS: error.
- **Error, 11, or rounds = 0.** Go to DONE. The outputs equal the latched inputs. err = 1 only for the error cases.
- **Otherwise.** Go to RUN with cnt = rounds.
- **One inverse round (RUN, one per cycle).** B is always the newly recovered B.
  - ternary: A = A′; B = (B′ − A′) mod 3; G = (G′ − B) mod 5. Bit 2 of A and B is forced to 0.
  - pentary: A = A′; B = (B′ − A′) mod 5; G = (G′ − B) mod 5.
- **RUN.** Apply one round to the working registers and decrement cnt. When cnt reaches 0 after the decrement, go to DONE.
- **DONE.** out_valid = 1, and the outputs and err hold stable while out_ready = 0. On out_ready, go to IDLE and drop out_valid.
- Modular subtraction is computed as x + (r − y) with a conditional subtract of r. The intermediate is 4 bits; there is no wrap beyond r.
- A new request is never accepted in the same cycle the result is consumed. The path DONE→IDLE takes one cycle.
- Reset, asynchronous at any time including mid-RUN:
  - state = IDLE, cnt = 0;
  - A_out/B_out/G_out = 0, err = 0, out_valid = 0, busy = 0;
  - in_ready = 1 once rst_n is high.

## Timing
- Latency from the accepting edge to out_valid: rounds + 1 cycles for a valid request with rounds ≥ 1; 1 cycle for rounds = 0, pass-through, or error.
- Throughput: one transaction per rounds + 2 cycles with out_ready held high.
- Outputs are registered. Nothing combinational runs from inputs to outputs except in_ready, which is decoded from the state register only.

## Structure
- Package rhea_pkg holds:
  - MODE_BIN, MODE_TER, MODE_PENT, MODE_PASS localparams;
  - TER_MAX = 2 and PENT_MAX = 4;
  - sub_mod3 and sub_mod5 functions;
  - the state enum typedef.
- Sub-module rhea_inverse_round is a combinational single inverse round (mode, A′, B′, G′ → A, B, G). RUN instantiates it once, with feedback through the working registers.

## Test plan
- Pentary, (3,1,2), rounds = 1 → (3,3,4), err = 0, out_valid 2 cycles after accept.
- Ternary, (2,0,1), rounds = 1 → (2,1,0), err = 0. Bit 2 of A_out and B_out is 0.
- Pentary, (1,4,3), rounds = 2 → (1,2,3) after 3 cycles. The intermediate working value after round 1 is (1,3,0).
- Error and pass-through cases:
  - pentary, A = 5 → err = 1, outputs (5,B,G), latency 1;
  - mode 00 → err = 1;
  - mode 11 → err = 0, outputs = inputs.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE → outputs stable and in_ready = 0. Raise out_ready → IDLE next cycle.
- Assert rst_n = 0 mid-RUN (rounds = 6, cycle 3) → all outputs 0 immediately. After release, a fresh request completes correctly.
